// File: rtl/usb_pkg.sv
// Shared encodings and defaults for the USB device transaction sequencer.
package usb_pkg;

  localparam int unsigned TURNAROUND_DEFAULT = 18;
  localparam int unsigned TIMEOUT_DEFAULT    = 162;
  localparam int unsigned MAX_PKT            = 64;

  // PID codes reported by usb_rx
  typedef enum logic [2:0] {
    RxNone  = 3'd0,
    RxOut   = 3'd1,
    RxIn    = 3'd2,
    RxData0 = 3'd3,
    RxData1 = 3'd4,
    RxAck   = 3'd5,
    RxNak   = 3'd6,
    RxStall = 3'd7
  } rx_pid_e;

  // PID codes accepted by usb_tx
  typedef enum logic [2:0] {
    TxNone  = 3'd0,
    TxData0 = 3'd1,
    TxData1 = 3'd2,
    TxAck   = 3'd3,
    TxNak   = 3'd4,
    TxStall = 3'd5
  } tx_pid_e;

  // Sequencer states kept as plain constants so older tools can consume them
  typedef logic [2:0] state_t;
  localparam state_t StIdle     = 3'd0;
  localparam state_t StWaitData = 3'd1;
  localparam state_t StDelay    = 3'd2;
  localparam state_t StSend     = 3'd3;
  localparam state_t StWaitTx   = 3'd4;
  localparam state_t StWaitAck  = 3'd5;

  // DATAx reply code for a given toggle value (0 = DATA0)
  function automatic logic [2:0] data_pid(input logic tog);
    return tog ? TxData1 : TxData0;
  endfunction

  function automatic logic is_data(input logic [2:0] pid);
    return (pid == TxData0) || (pid == TxData1);
  endfunction

endpackage

// File: rtl/usb_txn_ctrl_if.sv
// Handshake bundle between the sequencer and usb_rx/usb_tx/FIFO/AHB side.
interface usb_txn_ctrl_if;
  logic [2:0] rx_packet;
  logic       rx_transfer_active;
  logic       rx_error;
  logic [6:0] buffer_occupancy;
  logic       tx_data_loaded;
  logic       tx_transfer_active;
  logic [2:0] tx_packet;
  logic       tx_start;
  logic       d_mode;
  logic       clear;
  logic       rx_done;
  logic       tx_done;
  logic       txn_error;

  // Environment side: packet decoder, transmitter, FIFO and AHB
  modport master (
    output rx_packet, rx_transfer_active, rx_error, buffer_occupancy, tx_data_loaded,
           tx_transfer_active,
    input  tx_packet, tx_start, d_mode, clear, rx_done, tx_done, txn_error
  );

  // Sequencer side
  modport slave (
    input  rx_packet, rx_transfer_active, rx_error, buffer_occupancy, tx_data_loaded,
           tx_transfer_active,
    output tx_packet, tx_start, d_mode, clear, rx_done, tx_done, txn_error
  );
endinterface

// File: rtl/usb_txn_timer.sv
// Loadable 8-bit up-counter that stops at its limit and flags arrival there.
module usb_txn_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] count_q;

  assign done = (count_q == limit);

  // Restart on load; otherwise count up, holding at the limit or at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= 8'd0;
    end else if (enable && !done && (count_q != 8'hff)) begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/usb_txn_ctrl.sv
// Device-side USB transaction sequencer: handshake decisions, turnaround,
// DATA0/DATA1 toggles and FIFO ownership. TURNAROUND must be at least 1.
module usb_txn_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned TURNAROUND = TURNAROUND_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  usb_txn_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  logic [2:0] reply_q, reply_d;
  logic [2:0] tx_packet_q, tx_packet_d;
  logic       out_nak_q, out_nak_d;
  logic       rx_tog_q, rx_tog_d;
  logic       tx_tog_q, tx_tog_d;
  logic       d_mode_q, d_mode_d;
  logic       clear_q, clear_d;
  logic       rx_done_q, rx_done_d;
  logic       tx_done_q, tx_done_d;
  logic       err_q, err_d;
  logic       rx_act_q, tx_act_q;

  logic       eop, rx_rise, tx_fall, data_tog;
  logic       timer_load, timer_en, timer_done;
  logic [7:0] timer_limit;

  assign eop      = rx_act_q & ~bus.rx_transfer_active;
  assign rx_rise  = ~rx_act_q & bus.rx_transfer_active;
  assign tx_fall  = tx_act_q & ~bus.tx_transfer_active;
  assign data_tog = (bus.rx_packet == RxData1);

  // One timer serves both the turnaround delay and the packet timeouts
  assign timer_limit = (state_q == StDelay) ? 8'(TURNAROUND - 1) : 8'(TIMEOUT);
  assign timer_en    = (state_q == StDelay) || (state_q == StWaitData) ||
                       (state_q == StWaitAck);
  assign timer_load  = (state_d != state_q) ||
                       (rx_rise && ((state_q == StWaitData) || (state_q == StWaitAck)));

  usb_txn_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .enable (timer_en),
    .limit  (timer_limit),
    .done   (timer_done)
  );

  // Next-state and registered-output decisions, all taken on EOP or timer events
  always_comb begin
    state_d     = state_q;
    reply_d     = reply_q;
    tx_packet_d = tx_packet_q;
    out_nak_d   = out_nak_q;
    rx_tog_d    = rx_tog_q;
    tx_tog_d    = tx_tog_q;
    d_mode_d    = d_mode_q;
    err_d       = err_q;
    clear_d     = 1'b0;
    rx_done_d   = 1'b0;
    tx_done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (eop) begin
          if (!bus.rx_error && (bus.rx_packet == RxOut)) begin
            state_d   = StWaitData;
            err_d     = 1'b0;
            // AHB has not drained the previous OUT payload yet
            out_nak_d = (bus.buffer_occupancy != 7'd0);
          end else if (!bus.rx_error && (bus.rx_packet == RxIn)) begin
            state_d = StDelay;
            err_d   = 1'b0;
            reply_d = bus.tx_data_loaded ? data_pid(tx_tog_q) : TxNak;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StWaitData: begin
        if (eop) begin
          if (!bus.rx_error && ((bus.rx_packet == RxData0) || (bus.rx_packet == RxData1))) begin
            state_d = StDelay;
            if (out_nak_q) begin
              reply_d = TxNak;
            end else begin
              reply_d = TxAck;
              if (data_tog == rx_tog_q) begin
                rx_done_d = 1'b1;
                rx_tog_d  = ~rx_tog_q;
              end else begin
                // Host retransmit of data already accepted: ACK but drop the copy
                clear_d = 1'b1;
              end
            end
          end else begin
            state_d = StIdle;
            clear_d = 1'b1;
            err_d   = 1'b1;
          end
        end else if (timer_done) begin
          state_d = StIdle;
          clear_d = 1'b1;
          err_d   = 1'b1;
        end
      end

      StDelay: begin
        if (rx_rise) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (timer_done) begin
          state_d     = StSend;
          tx_packet_d = reply_q;
          d_mode_d    = is_data(reply_q);
        end
      end

      StSend: begin
        if (rx_rise) begin
          state_d     = StIdle;
          err_d       = 1'b1;
          tx_packet_d = TxNone;
          d_mode_d    = 1'b0;
        end else begin
          state_d = StWaitTx;
        end
      end

      StWaitTx: begin
        if (tx_fall) begin
          state_d     = is_data(reply_q) ? StWaitAck : StIdle;
          tx_packet_d = TxNone;
          d_mode_d    = 1'b0;
        end
      end

      StWaitAck: begin
        if (eop) begin
          state_d = StIdle;
          if (!bus.rx_error && (bus.rx_packet == RxAck)) begin
            tx_done_d = 1'b1;
            tx_tog_d  = ~tx_tog_q;
            clear_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (timer_done) begin
          // FIFO contents are kept so the host can retry the IN
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end

      default: begin
        state_d     = StIdle;
        tx_packet_d = TxNone;
        d_mode_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      reply_q     <= TxNone;
      tx_packet_q <= TxNone;
      out_nak_q   <= 1'b0;
      rx_tog_q    <= 1'b0;
      tx_tog_q    <= 1'b0;
      d_mode_q    <= 1'b0;
      clear_q     <= 1'b0;
      rx_done_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      err_q       <= 1'b0;
      rx_act_q    <= 1'b0;
      tx_act_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      reply_q     <= reply_d;
      tx_packet_q <= tx_packet_d;
      out_nak_q   <= out_nak_d;
      rx_tog_q    <= rx_tog_d;
      tx_tog_q    <= tx_tog_d;
      d_mode_q    <= d_mode_d;
      clear_q     <= clear_d;
      rx_done_q   <= rx_done_d;
      tx_done_q   <= tx_done_d;
      err_q       <= err_d;
      rx_act_q    <= bus.rx_transfer_active;
      tx_act_q    <= bus.tx_transfer_active;
    end
  end

  assign bus.tx_packet = tx_packet_q;
  assign bus.tx_start  = (state_q == StSend);
  assign bus.d_mode    = d_mode_q;
  assign bus.clear     = clear_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.txn_error = err_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed bench for usb_txn_ctrl: OUT/IN transactions, toggles, timeouts, errors, reset.
module tb_usb_txn_ctrl;
  import usb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  usb_txn_ctrl_if bus();

  usb_txn_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Packet of 3 active cycles; returns in the cycle right after the EOP cycle
  task automatic send_pkt(input logic [2:0] pid, input logic err);
    bus.rx_packet          = pid;
    bus.rx_error           = 1'b0;
    bus.rx_transfer_active = 1'b1;
    tick(3);
    bus.rx_transfer_active = 1'b0;
    bus.rx_error           = err;
    tick(1);
    bus.rx_error           = 1'b0;
  endtask

  // Cycles from the EOP cycle to tx_start (60 if it never comes)
  task automatic wait_start(output int cyc);
    cyc = 1;
    while (!bus.tx_start && cyc < 60) begin
      tick(1);
      cyc++;
    end
  endtask

  // Emulate usb_tx after tx_start; checks ownership and held PID during transmission
  task automatic run_tx(input string tag, input logic [2:0] pid, input logic dmode);
    tick(1);
    bus.tx_transfer_active = 1'b1;
    tick(1);
    check({tag, " d_mode during tx"}, 8'(bus.d_mode), 8'(dmode));
    check({tag, " tx_packet held"}, 8'(bus.tx_packet), 8'(pid));
    tick(3);
    bus.tx_transfer_active = 1'b0;
    tick(1);
    check({tag, " d_mode after tx"}, 8'(bus.d_mode), 8'd0);
    check({tag, " tx_packet after tx"}, 8'(bus.tx_packet), 8'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " tx_packet"}, 8'(bus.tx_packet), 8'd0);
    check({tag, " tx_start"}, 8'(bus.tx_start), 8'd0);
    check({tag, " d_mode"}, 8'(bus.d_mode), 8'd0);
    check({tag, " clear"}, 8'(bus.clear), 8'd0);
    check({tag, " rx_done"}, 8'(bus.rx_done), 8'd0);
    check({tag, " tx_done"}, 8'(bus.tx_done), 8'd0);
    check({tag, " txn_error"}, 8'(bus.txn_error), 8'd0);
  endtask

  initial begin
    int cyc;
    int starts;

    rst                    = 1'b1;
    bus.rx_packet          = RxNone;
    bus.rx_transfer_active = 1'b0;
    bus.rx_error           = 1'b0;
    bus.buffer_occupancy   = 7'd0;
    bus.tx_data_loaded     = 1'b0;
    bus.tx_transfer_active = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // OUT + DATA0, empty FIFO: accepted, ACK after turnaround
    send_pkt(RxOut, 1'b0);
    tick(1);
    send_pkt(RxData0, 1'b0);
    check("out0 rx_done", 8'(bus.rx_done), 8'd1);
    check("out0 clear", 8'(bus.clear), 8'd0);
    wait_start(cyc);
    check("out0 tx_start latency", 8'(cyc), 8'd19);
    check("out0 reply", 8'(bus.tx_packet), 8'(TxAck));
    run_tx("out0", TxAck, 1'b0);

    // Retransmitted DATA0: ACK, flush, no rx_done
    send_pkt(RxOut, 1'b0);
    tick(1);
    send_pkt(RxData0, 1'b0);
    check("retx clear", 8'(bus.clear), 8'd1);
    check("retx rx_done", 8'(bus.rx_done), 8'd0);
    wait_start(cyc);
    check("retx tx_start latency", 8'(cyc), 8'd19);
    check("retx reply", 8'(bus.tx_packet), 8'(TxAck));
    run_tx("retx", TxAck, 1'b0);

    // DATA1 now expected
    send_pkt(RxOut, 1'b0);
    tick(1);
    send_pkt(RxData1, 1'b0);
    check("out1 rx_done", 8'(bus.rx_done), 8'd1);
    check("out1 clear", 8'(bus.clear), 8'd0);
    wait_start(cyc);
    run_tx("out1", TxAck, 1'b0);

    // IN with nothing staged: NAK
    bus.tx_data_loaded = 1'b0;
    send_pkt(RxIn, 1'b0);
    wait_start(cyc);
    check("in nak latency", 8'(cyc), 8'd19);
    check("in nak reply", 8'(bus.tx_packet), 8'(TxNak));
    run_tx("in nak", TxNak, 1'b0);

    // IN with data: DATA0, host ACK
    bus.tx_data_loaded = 1'b1;
    send_pkt(RxIn, 1'b0);
    wait_start(cyc);
    check("in0 reply", 8'(bus.tx_packet), 8'(TxData0));
    run_tx("in0", TxData0, 1'b1);
    send_pkt(RxAck, 1'b0);
    check("in0 tx_done", 8'(bus.tx_done), 8'd1);
    check("in0 clear", 8'(bus.clear), 8'd1);
    check("in0 txn_error", 8'(bus.txn_error), 8'd0);
    tick(1);
    check("in0 tx_done pulse", 8'(bus.tx_done), 8'd0);

    // IN with DATA1, no host ACK: timeout at 162 cycles
    send_pkt(RxIn, 1'b0);
    wait_start(cyc);
    check("in1 reply", 8'(bus.tx_packet), 8'(TxData1));
    run_tx("in1", TxData1, 1'b1);
    tick(160);
    check("ack timeout early", 8'(bus.txn_error), 8'd0);
    tick(5);
    check("ack timeout", 8'(bus.txn_error), 8'd1);

    // Retry: toggle unchanged, valid token clears the error
    send_pkt(RxIn, 1'b0);
    check("retry clears error", 8'(bus.txn_error), 8'd0);
    wait_start(cyc);
    check("retry reply", 8'(bus.tx_packet), 8'(TxData1));
    run_tx("retry", TxData1, 1'b1);
    send_pkt(RxAck, 1'b0);
    check("retry tx_done", 8'(bus.tx_done), 8'd1);

    // Host packet starting during turnaround aborts the reply
    bus.tx_data_loaded = 1'b0;
    send_pkt(RxIn, 1'b0);
    tick(4);
    bus.rx_packet          = RxNone;
    bus.rx_transfer_active = 1'b1;
    tick(1);
    check("abort error", 8'(bus.txn_error), 8'd1);
    tick(2);
    bus.rx_transfer_active = 1'b0;
    starts = 0;
    repeat (25) begin
      if (bus.tx_start) starts++;
      tick(1);
    end
    check("abort no tx_start", 8'(starts), 8'd0);

    // OUT then corrupted DATA0: flush and error, no reply
    send_pkt(RxOut, 1'b0);
    check("out clears error", 8'(bus.txn_error), 8'd0);
    tick(1);
    send_pkt(RxData0, 1'b1);
    check("bad data clear", 8'(bus.clear), 8'd1);
    check("bad data error", 8'(bus.txn_error), 8'd1);
    check("bad data rx_done", 8'(bus.rx_done), 8'd0);
    starts = 0;
    repeat (30) begin
      if (bus.tx_start) starts++;
      tick(1);
    end
    check("bad data no tx_start", 8'(starts), 8'd0);
    send_pkt(RxOut, 1'b0);
    check("next out clears error", 8'(bus.txn_error), 8'd0);
    tick(1);
    send_pkt(RxData0, 1'b0);
    check("good data rx_done", 8'(bus.rx_done), 8'd1);
    wait_start(cyc);
    run_tx("good data", TxAck, 1'b0);

    // FIFO not drained at OUT token: NAK, nothing accepted
    bus.buffer_occupancy = 7'd5;
    send_pkt(RxOut, 1'b0);
    bus.buffer_occupancy = 7'd0;
    tick(1);
    send_pkt(RxData1, 1'b0);
    check("busy rx_done", 8'(bus.rx_done), 8'd0);
    wait_start(cyc);
    check("busy reply", 8'(bus.tx_packet), 8'(TxNak));
    run_tx("busy", TxNak, 1'b0);

    // Reset while in turnaround delay
    bus.tx_data_loaded = 1'b1;
    send_pkt(RxIn, 1'b0);
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid reset");
    tick(2);
    rst = 1'b0;
    starts = 0;
    repeat (25) begin
      if (bus.tx_start) starts++;
      tick(1);
    end
    check("mid reset no tx_start", 8'(starts), 8'd0);

    // rx toggle was DATA1 before reset; DATA0 must now be accepted
    send_pkt(RxOut, 1'b0);
    tick(1);
    send_pkt(RxData0, 1'b0);
    check("post reset rx_done", 8'(bus.rx_done), 8'd1);
    wait_start(cyc);
    check("post reset latency", 8'(cyc), 8'd19);
    run_tx("post reset", TxAck, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
